// File: rtl/clk_div_pkg.sv
// Shared defaults and types for the clock-enable divider bank.
package clk_div_pkg;

  localparam int unsigned DIV_W_DFLT       = 27;
  localparam int unsigned DEFAULT_DIV_DFLT = 50_000_000;

  typedef logic [DIV_W_DFLT-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: programmable ratio, free-running count, tick strobe
// and 50 % square wave. A local write restarts the phase.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned            DIV_W       = DIV_W_DFLT,
  parameter logic [DIV_W-1:0]       DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             led_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             led_q, led_d;
  logic             running;
  logic             terminal;

  assign running  = en_i && (div_q != '0);
  assign terminal = (cnt_q == (div_q - DIV_W'(1)));

  // A write takes priority over the terminal count on the same edge.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    led_d  = led_q;
    if (wr_i) begin
      div_d = wr_div_i;
      cnt_d = '0;
    end else if (running) begin
      if (terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        led_d  = ~led_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      led_q  <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CHANNELS independent clock-enable dividers with a shared ratio
// write port and an out-of-range write error pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 16,
  parameter int unsigned DIV_W       = DIV_W_DFLT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DFLT,
  parameter int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [DIV_W-1:0]    wr_div,
  output logic                wr_err,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] led
);

  logic wr_valid;
  logic wr_err_q, wr_err_d;

  // Widened compare so any CH_W up to 32 bits is handled uniformly.
  assign wr_valid = (33'(wr_ch) < 33'(CHANNELS));

  always_comb begin
    wr_err_d = wr_en && !wr_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    logic wr_sel;

    assign wr_sel = wr_en && wr_valid && (wr_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[g]),
      .wr_i     (wr_sel),
      .wr_div_i (wr_div),
      .tick_o   (tick[g]),
      .led_o    (led[g])
    );
  end

endmodule
